// File: rtl/fwd_hazard_ctrl_pkg.sv
// fwd_hazard_ctrl_pkg: forwarding select encodings and the per-stage shadow entry.
// Shared by the hazard controller top and its per-operand select block.
package fwd_hazard_ctrl_pkg;
    localparam int RADDR_W = 5;
    localparam int NSRC    = 2;
    localparam int SEL_W   = 3;
    localparam logic [SEL_W-1:0] FWD_SRC_GR      = 3'd0;
    localparam logic [SEL_W-1:0] FWD_SRC_EX      = 3'd1;
    localparam logic [SEL_W-1:0] FWD_SRC_MM1     = 3'd2;
    localparam logic [SEL_W-1:0] FWD_SRC_MM2_REG = 3'd3;
    localparam logic [SEL_W-1:0] FWD_SRC_MM2_MEM = 3'd4;
    localparam logic [SEL_W-1:0] FWD_SRC_WB      = 3'd5;

    typedef struct packed {
        logic               v;
        logic [RADDR_W-1:0] rd;
        logic               we;
        logic               ld;
    } shadow_t;

    localparam int SH_W = $bits(shadow_t);

    function automatic logic hit(shadow_t e, logic [RADDR_W-1:0] src, logic en);
        return en & e.v & e.we & (e.rd == src) & (src != '0);
    endfunction
endpackage

// File: rtl/fwd_sel_one.sv
// fwd_sel_one: match and youngest-first priority for one source operand.
// Loads still in EX/MM1 have no data yet, so they stall and read GR.
module fwd_sel_one
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic               i_id_valid,
    input  logic [RADDR_W-1:0] i_src,
    input  logic               i_used,
    input  logic [SH_W-1:0]    i_ex,
    input  logic [SH_W-1:0]    i_mm1,
    input  logic [SH_W-1:0]    i_mm2,
    input  logic [SH_W-1:0]    i_wb,
    output logic [SEL_W-1:0]   o_sel,
    output logic               o_stall
);
    shadow_t w_ex, w_mm1, w_mm2, w_wb;
    logic    w_en, w_h_ex, w_h_mm1, w_h_mm2, w_h_wb;

    assign w_ex    = i_ex;
    assign w_mm1   = i_mm1;
    assign w_mm2   = i_mm2;
    assign w_wb    = i_wb;
    assign w_en    = i_id_valid & i_used;
    assign w_h_ex  = hit(w_ex, i_src, w_en);
    assign w_h_mm1 = hit(w_mm1, i_src, w_en);
    assign w_h_mm2 = hit(w_mm2, i_src, w_en);
    assign w_h_wb  = hit(w_wb, i_src, w_en);

    assign o_sel = w_h_ex  ? (w_ex.ld  ? FWD_SRC_GR      : FWD_SRC_EX)
                 : w_h_mm1 ? (w_mm1.ld ? FWD_SRC_GR      : FWD_SRC_MM1)
                 : w_h_mm2 ? (w_mm2.ld ? FWD_SRC_MM2_MEM : FWD_SRC_MM2_REG)
                 : w_h_wb  ? FWD_SRC_WB : FWD_SRC_GR;
    assign o_stall = w_h_ex ? w_ex.ld : (w_h_mm1 & w_mm1.ld);
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: ID-stage forwarding selects and load-use stall from a shadow of EX..WB.
// Optional FWD_PERF_EN adds stall_cnt, a wrapping count of stalled, non-flush cycles.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rj,
    input  logic [RADDR_W-1:0] id_rk,
    input  logic               id_rj_used,
    input  logic               id_rk_used,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_gr_we,
    input  logic               id_is_load,
    input  logic               ex_allowin,
    input  logic               mm1_allowin,
    input  logic               mm2_allowin,
    input  logic               wb_allowin,
    input  logic               flush,
    output logic [SEL_W-1:0]   fwd_ctrl_rj,
    output logic [SEL_W-1:0]   fwd_ctrl_rk,
    output logic               id_stall,
`ifdef FWD_PERF_EN
    output logic [31:0]        stall_cnt,
`endif
    output logic               id_go
);
    shadow_t          r_ex, r_mm1, r_mm2, r_wb;
    shadow_t          w_ex_in;
    logic [NSRC-1:0]  w_stall;

    assign w_ex_in  = '{v: id_go, rd: id_rd, we: id_gr_we, ld: id_is_load};
    assign id_stall = |w_stall;
    assign id_go    = id_valid & ~id_stall & ex_allowin;

    // Flush only kills EX..MM2; whatever sits in MM2 still retires into WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex  <= '0;
            r_mm1 <= '0;
            r_mm2 <= '0;
            r_wb  <= '0;
        end else begin
            r_ex  <= flush ? '0 : ex_allowin  ? w_ex_in : r_ex;
            r_mm1 <= flush ? '0 : mm1_allowin ? r_ex    : r_mm1;
            r_mm2 <= flush ? '0 : mm2_allowin ? r_mm1   : r_mm2;
            r_wb  <= wb_allowin ? r_mm2 : r_wb;
        end
    end

`ifdef FWD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) stall_cnt <= '0;
        else if (id_stall & ~flush) stall_cnt <= stall_cnt + 32'd1;
    end
`endif

    fwd_sel_one u_rj (
        .i_id_valid(id_valid), .i_src(id_rj), .i_used(id_rj_used),
        .i_ex(r_ex), .i_mm1(r_mm1), .i_mm2(r_mm2), .i_wb(r_wb),
        .o_sel(fwd_ctrl_rj), .o_stall(w_stall[0])
    );
    fwd_sel_one u_rk (
        .i_id_valid(id_valid), .i_src(id_rk), .i_used(id_rk_used),
        .i_ex(r_ex), .i_mm1(r_mm1), .i_mm2(r_mm2), .i_wb(r_wb),
        .o_sel(fwd_ctrl_rk), .o_stall(w_stall[1])
    );
endmodule
